// File: rtl/tx_phy_pkg.sv
// tx_phy_pkg: shared TX PHY definitions.
//   RATE_* : 4-bit RATE field codes handled by the interleaver path.
//   ncbps(rate)   : coded bits per OFDM symbol, 0 when the rate is not handled.
//   rate_ok(rate) : rate is one of the handled codes.
//   seq_state_t   : interleaver_seq frame states.
package tx_phy_pkg;

  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_24 = 4'b1001;

  typedef enum logic [2:0] {
    IDLE,
    CFG_SIG,
    SIG,
    CFG_DAT,
    DATA,
    FLUSH
  } seq_state_t;

  function automatic logic [7:0] ncbps(input logic [3:0] rate);
    case (rate)
      RATE_6:  return 8'd48;
      RATE_12: return 8'd96;
      RATE_24: return 8'd192;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic rate_ok(input logic [3:0] rate);
    return ncbps(rate) != 8'd0;
  endfunction

endpackage

// File: rtl/interleaver_seq.sv
// interleaver_seq: frame sequencer for the TX interleaver.
// Loads the SIGNAL symbol (always 6 Mbit/s), then iNsym DATA symbols, then a
// flush symbol so the last loaded symbol drains out. Rate changes happen only
// in the one-cycle CFG states. Produces the real output-valid qualifier.
// Ports:
//   iClk, iRst            clock, async active-high reset
//   iStart, iRate, iNsym  frame request (sampled in IDLE only)
//   iInValid / oInReady   upstream coded-bit handshake
//   oIlvEN, oIlvRateEN, oIlvRate  interleaver controls
//   oFlush                interleaver iData must be forced to 0
//   oOutValid, oOutLast   qualify interleaver oData
//   oBusy, oDone, oErr    status (oDone/oErr registered pulses)
module interleaver_seq
  import tx_phy_pkg::*;
#(
  parameter int SYM_W = 11
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [3:0]       iRate,
  input  logic [SYM_W-1:0] iNsym,
  input  logic             iInValid,
  output logic             oInReady,
  output logic             oIlvEN,
  output logic             oIlvRateEN,
  output logic [3:0]       oIlvRate,
  output logic             oFlush,
  output logic             oOutValid,
  output logic             oOutLast,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr
);

  localparam logic [SYM_W-1:0] ONE = 1;

  seq_state_t       state;
  logic [3:0]       rateQ;
  logic [SYM_W-1:0] nsymQ;
  logic [SYM_W-1:0] symCnt;
  logic [7:0]       bitCnt;
  logic [7:0]       drainLeft;

  logic [7:0] curN;
  logic       xfer;
  logic       lastBit;
  logic       symDone;
  logic       flushEnd;

  // Symbol size of whatever is being loaded/flushed right now. The flush
  // drains the last loaded symbol, which is the SIG symbol when iNsym was 0.
  always_comb begin
    curN = 8'd0;
    case (state)
      SIG:     curN = 8'd48;
      DATA:    curN = ncbps(rateQ);
      FLUSH:   curN = (nsymQ == '0) ? 8'd48 : ncbps(rateQ);
      default: curN = 8'd0;
    endcase
  end

  assign oInReady   = (state == SIG) || (state == DATA);
  assign xfer       = iInValid & oInReady;
  assign oFlush     = (state == FLUSH);
  assign oIlvEN     = xfer | oFlush;
  assign oIlvRateEN = (state == CFG_SIG) || (state == CFG_DAT);
  assign oIlvRate   = (state == CFG_SIG) ? RATE_6 : rateQ;
  assign oBusy      = (state != IDLE);

  assign lastBit  = (bitCnt == curN - 8'd1);
  assign symDone  = xfer & lastBit;
  assign flushEnd = oFlush & lastBit;

  // Interleaver output is real only while the previous symbol still has bits
  // left; a larger symbol following a smaller one reads past the old data.
  assign oOutValid = oIlvEN & (drainLeft != 8'd0);
  assign oOutLast  = oOutValid & oFlush & (drainLeft == 8'd1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      rateQ     <= RATE_6;
      nsymQ     <= '0;
      symCnt    <= '0;
      bitCnt    <= 8'd0;
      drainLeft <= 8'd0;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;

      if (symDone || flushEnd)
        bitCnt <= 8'd0;
      else if (oIlvEN)
        bitCnt <= bitCnt + 8'd1;

      // A completed symbol becomes the one being drained; reload wins over
      // the decrement on its final enable.
      if (symDone)
        drainLeft <= curN;
      else if (oIlvEN && drainLeft != 8'd0)
        drainLeft <= drainLeft - 8'd1;

      case (state)
        IDLE: begin
          if (iStart) begin
            if (rate_ok(iRate)) begin
              state     <= CFG_SIG;
              rateQ     <= iRate;
              nsymQ     <= iNsym;
              symCnt    <= '0;
              bitCnt    <= 8'd0;
              drainLeft <= 8'd0;
            end else begin
              oErr <= 1'b1;
            end
          end
        end
        CFG_SIG: state <= SIG;
        SIG: begin
          if (symDone)
            state <= (nsymQ == '0) ? FLUSH : CFG_DAT;
        end
        CFG_DAT: state <= DATA;
        DATA: begin
          if (symDone) begin
            symCnt <= symCnt + ONE;
            if (symCnt == nsymQ - ONE)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flushEnd) begin
            state <= IDLE;
            oDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_seq.sv
// tb_interleaver_seq: directed frames with random upstream stalls and
// random junk on frame inputs while busy, checked cycle by cycle against a
// symbol-level model: a frame is the SIG symbol (48), iNsym DATA symbols of
// the rate size, then a flush the size of the last symbol; an enable carries
// a real bit when its index within the current symbol is below the size of
// the previous symbol.
module tb_interleaver_seq;

  localparam logic [3:0] R6  = 4'b1101;
  localparam logic [3:0] R12 = 4'b0101;
  localparam logic [3:0] R24 = 4'b1001;
  localparam int LIMIT = 4000;

  logic        iClk, iRst, iStart, iInValid;
  logic [3:0]  iRate;
  logic [10:0] iNsym;
  logic        oInReady, oIlvEN, oIlvRateEN, oFlush, oOutValid, oOutLast;
  logic        oBusy, oDone, oErr;
  logic [3:0]  oIlvRate;

  int tests = 0;
  int failed = 0;
  logic [3:0] lastRate;

  interleaver_seq #(.SYM_W(11)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iRate(iRate), .iNsym(iNsym),
    .iInValid(iInValid), .oInReady(oInReady), .oIlvEN(oIlvEN),
    .oIlvRateEN(oIlvRateEN), .oIlvRate(oIlvRate), .oFlush(oFlush),
    .oOutValid(oOutValid), .oOutLast(oOutLast), .oBusy(oBusy),
    .oDone(oDone), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chkB(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkI(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rateBits(input logic [3:0] r);
    if (r == R6)  return 48;
    if (r == R12) return 96;
    if (r == R24) return 192;
    return 0;
  endfunction

  // Junk on the frame inputs while busy must be ignored by the DUT.
  task automatic noise(input int pct);
    iInValid = ($urandom_range(99) < pct);
    iStart   = ($urandom_range(7) == 0);
    iRate    = 4'($urandom);
    iNsym    = 11'($urandom);
  endtask

  task automatic cfgCycle(input string tag, input logic [3:0] expRate, input int pct);
    @(negedge iClk); noise(pct); #1;
    chkB({tag, ".rateEn"}, oIlvRateEN, 1'b1);
    chkI({tag, ".rate"}, int'(oIlvRate), int'(expRate));
    chkB({tag, ".ilvEn"}, oIlvEN, 1'b0);
    chkB({tag, ".inReady"}, oInReady, 1'b0);
    chkB({tag, ".outValid"}, oOutValid, 1'b0);
    chkB({tag, ".busy"}, oBusy, 1'b1);
  endtask

  // abortAt >= 0: assert reset after that many cycles of the first DATA symbol.
  task automatic runFrame(input logic [3:0] rate, input int nsym, input int pct,
                          input int abortAt, input int expTotal);
    int n, cur, prev, j, cyc, vcnt;
    logic fl, en, expV;
    n = rateBits(rate);
    vcnt = 0;
    @(negedge iClk);
    iStart = 1'b1; iRate = rate; iNsym = 11'(nsym); iInValid = 1'b1; #1;
    chkB("start.busy", oBusy, 1'b0);
    chkB("start.ilvEn", oIlvEN, 1'b0);
    cfgCycle("cfgSig", R6, pct);
    for (int s = 0; s <= nsym + 1; s++) begin
      fl   = (s == nsym + 1);
      cur  = fl ? ((nsym == 0) ? 48 : n) : ((s == 0) ? 48 : n);
      prev = (s == 0) ? 0 : ((s == 1) ? 48 : n);
      if (s == 1 && !fl) cfgCycle("cfgDat", rate, pct);
      j = 0; cyc = 0;
      while (j < cur) begin
        @(negedge iClk); noise(pct);
        if (abortAt >= 0 && s == 1 && !fl && cyc == abortAt) begin
          iRst = 1'b1; #1;
          chkB("rst.busy", oBusy, 1'b0);
          chkB("rst.inReady", oInReady, 1'b0);
          chkB("rst.ilvEn", oIlvEN, 1'b0);
          chkB("rst.rateEn", oIlvRateEN, 1'b0);
          chkB("rst.flush", oFlush, 1'b0);
          chkB("rst.outValid", oOutValid, 1'b0);
          chkB("rst.outLast", oOutLast, 1'b0);
          chkB("rst.done", oDone, 1'b0);
          chkB("rst.err", oErr, 1'b0);
          chkI("rst.rate", int'(oIlvRate), int'(R6));
          @(negedge iClk); iRst = 1'b0; iStart = 1'b0;
          lastRate = R6;
          return;
        end
        #1;
        en   = fl ? 1'b1 : iInValid;
        expV = en && (j < prev);
        chkB("inReady", oInReady, !fl);
        chkB("ilvEn", oIlvEN, en);
        chkB("flush", oFlush, fl);
        chkB("rateEn", oIlvRateEN, 1'b0);
        chkI("rate", int'(oIlvRate), int'(rate));
        chkB("busy", oBusy, 1'b1);
        chkB("outValid", oOutValid, expV);
        chkB("outLast", oOutLast, expV && fl && (j == cur - 1));
        chkB("done", oDone, 1'b0);
        if (oOutValid) vcnt++;
        if (en) j++;
        cyc++;
        if (cyc > LIMIT) begin
          tests++; failed++;
          $error("FAIL symTimeout observed=%0d expected<=%0d", cyc, LIMIT);
          return;
        end
      end
    end
    @(negedge iClk); iStart = 1'b0; iInValid = 1'b0; #1;
    chkB("end.done", oDone, 1'b1);
    chkB("end.busy", oBusy, 1'b0);
    chkB("end.ilvEn", oIlvEN, 1'b0);
    chkI("end.rate", int'(oIlvRate), int'(rate));
    chkI("validCount", vcnt, expTotal);
    @(negedge iClk); #1;
    chkB("end.donePulse", oDone, 1'b0);
    lastRate = rate;
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iRate = 4'd0; iNsym = 11'd0; iInValid = 1'b0;
    lastRate = R6;
    #1;
    chkB("reset.busy", oBusy, 1'b0);
    chkB("reset.inReady", oInReady, 1'b0);
    chkB("reset.ilvEn", oIlvEN, 1'b0);
    chkB("reset.done", oDone, 1'b0);
    chkB("reset.err", oErr, 1'b0);
    chkI("reset.rate", int'(oIlvRate), int'(R6));
    @(negedge iClk); @(negedge iClk);
    iRst = 1'b0;

    runFrame(R6, 2, 100, -1, 144);
    runFrame(R24, 1, 100, -1, 240);
    runFrame(R12, 3, 50, -1, 336);

    // Unsupported rate: error pulse only.
    @(negedge iClk);
    iStart = 1'b1; iRate = 4'b0011; iNsym = 11'd4; #1;
    chkB("err.busyBefore", oBusy, 1'b0);
    @(negedge iClk); iStart = 1'b0; #1;
    chkB("err.pulse", oErr, 1'b1);
    chkB("err.busy", oBusy, 1'b0);
    chkB("err.rateEn", oIlvRateEN, 1'b0);
    chkI("err.rate", int'(oIlvRate), int'(lastRate));
    @(negedge iClk); #1;
    chkB("err.pulseEnd", oErr, 1'b0);
    chkB("err.rateEn2", oIlvRateEN, 1'b0);

    runFrame(R24, 0, 100, -1, 48);
    runFrame(R12, 3, 50, 20, 0);
    @(negedge iClk); #1;
    chkB("postRst.busy", oBusy, 1'b0);
    runFrame(R6, 1, 50, -1, 96);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
